// File: rtl/sequence_checker.sv
// sequence_checker: game-side partner of the seven-segment sequence display.
// Latches a random four-digit one-cold target from a free-running LFSR and
// launches the display with it. It then checks the player's digit at each
// button_next press and reports solve or strike to the game controller.
//
// Build option: define SEQ_CHECK_EARLY_FAIL_EN to abort with a strike on the
// first wrong digit. When it is undefined, all four digits are judged
// together after the fourth press.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; target from the previous game still shown
// ARM    | one cycle, display = 8'h10 launches the display preview
// SHOW   | counting one_sec ticks while the display previews the target
// ENTER  | capturing digits on button_next, timeout counter running
// JUDGE  | one cycle, decide solve or strike from the mismatch flag
// DONE   | solved held high until the next start

module sequence_checker #(
  parameter int          SHOW_SECS    = 3,
  parameter int          TIMEOUT_SECS = 30,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        one_sec,
  input  logic        button_next,
  input  logic [3:0]  seq_digit,
  output logic [15:0] sequence_in,
  output logic [7:0]  display,
  output logic        busy,
  output logic        solved,
  output logic        strike
);

  localparam int MAX_SECS = (SHOW_SECS > TIMEOUT_SECS) ? SHOW_SECS : TIMEOUT_SECS;
  localparam int CNT_W    = $clog2(MAX_SECS + 1);

  localparam logic [CNT_W-1:0] SHOW_CNT    = CNT_W'(SHOW_SECS);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_SECS);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  localparam logic [7:0] DISPLAY_GO = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SHOW  = 3'd2,
    ST_ENTER = 3'd3,
    ST_JUDGE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       seq_q, seq_d;
  logic [7:0]        display_q, display_d;
  logic              busy_q, busy_d;
  logic              solved_q, solved_d;
  logic              strike_q, strike_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              mis_q, mis_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic [3:0]        cur_nibble;
  logic              digit_ok;

  // Maps a 2-bit LFSR field onto a one-cold digit code.
  function automatic logic [3:0] field_to_digit(input logic [1:0] f);
    logic [3:0] d;
    case (f)
      2'b00:   d = 4'b1110;
      2'b01:   d = 4'b1101;
      2'b10:   d = 4'b1011;
      default: d = 4'b0111;
    endcase
    return d;
  endfunction

  // Nibble k of the target comes from LFSR bits [2k+1:2k].
  function automatic logic [15:0] make_target(input logic [15:0] l);
    return {field_to_digit(l[7:6]), field_to_digit(l[5:4]),
            field_to_digit(l[3:2]), field_to_digit(l[1:0])};
  endfunction

  // The seconds counter saturates at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  // Select the target nibble for the current entry index (3 = first digit).
  always_comb begin
    cur_nibble = seq_q[3:0];
    case (idx_q)
      2'd3:    cur_nibble = seq_q[15:12];
      2'd2:    cur_nibble = seq_q[11:8];
      2'd1:    cur_nibble = seq_q[7:4];
      default: cur_nibble = seq_q[3:0];
    endcase
  end

  // Target nibbles are always valid one-cold codes, so any invalid input
  // code fails this equality on its own.
  assign digit_ok = (seq_digit == cur_nibble);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mis_d    = mis_q;
    strike_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          seq_d   = make_target(lfsr_q);
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        cnt_d   = '0;
        state_d = ST_SHOW;
      end

      ST_SHOW: begin
        if (one_sec) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= SHOW_CNT) begin
            state_d = ST_ENTER;
            idx_d   = 2'd3;
            mis_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      ST_ENTER: begin
        // A press takes priority over a coincident tick; the tick is dropped.
        if (button_next) begin
`ifdef SEQ_CHECK_EARLY_FAIL_EN
          if (!digit_ok) begin
            strike_d = 1'b1;
            state_d  = ST_IDLE;
          end else if (idx_q == 2'd0) begin
            state_d = ST_JUDGE;
          end else begin
            idx_d = idx_q - 2'd1;
          end
`else
          mis_d = mis_q | ~digit_ok;
          if (idx_q == 2'd0) begin
            state_d = ST_JUDGE;
          end else begin
            idx_d = idx_q - 2'd1;
          end
`endif
        end else if (one_sec) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT_CNT) begin
            strike_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      ST_JUDGE: begin
        if (mis_q) begin
          strike_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    display_d = (state_d == ST_ARM) ? DISPLAY_GO : 8'h00;
    busy_d    = (state_d == ST_ARM) || (state_d == ST_SHOW) ||
                (state_d == ST_ENTER) || (state_d == ST_JUDGE);
    solved_d  = (state_d == ST_DONE);
  end

  // State, LFSR, target and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      seq_q     <= 16'hFFFF;
      display_q <= 8'h00;
      busy_q    <= 1'b0;
      solved_q  <= 1'b0;
      strike_q  <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= 2'd3;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      seq_q     <= seq_d;
      display_q <= display_d;
      busy_q    <= busy_d;
      solved_q  <= solved_d;
      strike_q  <= strike_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      mis_q     <= mis_d;
    end
  end

  assign sequence_in = seq_q;
  assign display     = display_q;
  assign busy        = busy_q;
  assign solved      = solved_q;
  assign strike      = strike_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Randomized self-checking bench for sequence_checker.
module tb_sequence_checker;

  localparam int          SHOW_SECS    = 3;
  localparam int          TIMEOUT_SECS = 30;
  localparam logic [15:0] SEED         = 16'hACE1;
  localparam int          WAIT_AFTER_RST = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        one_sec;
  logic        button_next;
  logic [3:0]  seq_digit;
  logic [15:0] sequence_in;
  logic [7:0]  display;
  logic        busy;
  logic        solved;
  logic        strike;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] first_tgt;

  sequence_checker #(
    .SHOW_SECS    (SHOW_SECS),
    .TIMEOUT_SECS (TIMEOUT_SECS),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .one_sec     (one_sec),
    .button_next (button_next),
    .seq_digit   (seq_digit),
    .sequence_in (sequence_in),
    .display     (display),
    .busy        (busy),
    .solved      (solved),
    .strike      (strike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11 (1-based), free running, reseeded by reset.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Target from the spec rule: field value f selects the single zero bit f.
  function automatic logic [15:0] expand(input logic [15:0] l);
    logic [15:0] t;
    int f;
    t = 16'h0;
    for (int k = 0; k < 4; k++) begin
      f = int'((l >> (2 * k)) & 16'h3);
      t = t | (16'((15 - (1 << f))) << (4 * k));
    end
    return t;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] t, input int pos);
    return 4'((t >> (4 * (3 - pos))) & 16'hF);
  endfunction

  function automatic bit one_cold(input logic [3:0] d);
    return (d == 4'hE) || (d == 4'hD) || (d == 4'hB) || (d == 4'h7);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    start       = 1'b0;
    one_sec     = 1'b0;
    button_next = 1'b0;
  endtask

  // Start a game and run it through ARM and SHOW with ignored noise inputs.
  task automatic start_show(output logic [15:0] tgt);
    int gap;
    tgt   = expand(m_lfsr);
    start = 1'b1;
    tick();
    clear_pulses();
    check("arm_display", 32'(display), 32'h10);
    check("arm_busy", 32'(busy), 32'h1);
    check("arm_solved", 32'(solved), 32'h0);
    check("target", 32'(sequence_in), 32'(tgt));
    tick();
    check("show_display", 32'(display), 32'h0);
    for (int s = 0; s < SHOW_SECS; s++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        start       = 1'($urandom_range(0, 1));
        button_next = 1'($urandom_range(0, 1));
        seq_digit   = 4'($urandom);
        tick();
        clear_pulses();
        check("show_gap_display", 32'(display), 32'h0);
        check("show_gap_busy", 32'(busy), 32'h1);
        check("show_gap_strike", 32'(strike), 32'h0);
      end
      one_sec     = 1'b1;
      start       = 1'($urandom_range(0, 1));
      button_next = 1'($urandom_range(0, 1));
      seq_digit   = 4'($urandom);
      tick();
      clear_pulses();
      check("show_tick_display", 32'(display), 32'h0);
      check("show_tick_busy", 32'(busy), 32'h1);
      check("show_tick_strike", 32'(strike), 32'h0);
    end
  endtask

  // Full four-digit game; wrong_at = -1 for a clean entry.
  task automatic play_entry(input int wrong_at);
    logic [15:0] tgt;
    logic [3:0]  d;
    bit          mism;
    bit          aborted;
    int          gap;
    start_show(tgt);
    mism    = 1'b0;
    aborted = 1'b0;
    for (int p = 0; p < 4; p++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        one_sec = ($urandom_range(0, 2) == 0);
        tick();
        clear_pulses();
        if (!aborted) begin
          check("enter_gap_strike", 32'(strike), 32'h0);
          check("enter_gap_busy", 32'(busy), 32'h1);
        end
      end
      d = nib(tgt, p);
      if (p == wrong_at) begin
        if ($urandom_range(0, 1) == 1) begin
          d = {d[2:0], d[3]};
        end else begin
          do d = 4'($urandom); while (one_cold(d));
        end
        mism = 1'b1;
      end
      button_next = 1'b1;
      seq_digit   = d;
      one_sec     = ($urandom_range(0, 3) == 0);
      tick();
      clear_pulses();
      if (aborted) begin
        check("ignored_press_strike", 32'(strike), 32'h0);
        check("ignored_press_solved", 32'(solved), 32'h0);
        check("ignored_press_busy", 32'(busy), 32'h0);
        continue;
      end
`ifdef SEQ_CHECK_EARLY_FAIL_EN
      if (p == wrong_at) begin
        check("early_strike", 32'(strike), 32'h1);
        check("early_busy", 32'(busy), 32'h0);
        aborted = 1'b1;
        continue;
      end
`endif
      check("press_strike", 32'(strike), 32'h0);
      check("press_busy", 32'(busy), 32'h1);
    end
    if (aborted) begin
      tick();
      check("early_after_strike", 32'(strike), 32'h0);
      return;
    end
    check("judge_busy", 32'(busy), 32'h1);
    check("judge_solved", 32'(solved), 32'h0);
    tick();
    check("result_strike", 32'(strike), 32'(mism));
    check("result_solved", 32'(solved), 32'(!mism));
    check("result_busy", 32'(busy), 32'h0);
    tick();
    check("post_strike", 32'(strike), 32'h0);
    check("post_solved", 32'(solved), 32'(!mism));
  endtask

  // Timeout game; coincide puts a press on the last allowed tick.
  task automatic play_timeout(input bit coincide);
    logic [15:0] tgt;
    int          npress;
    int          gap;
    start_show(tgt);
    npress = int'($urandom_range(0, 2));
    for (int p = 0; p < npress; p++) begin
      repeat ($urandom_range(0, 2)) tick();
      button_next = 1'b1;
      seq_digit   = nib(tgt, p);
      tick();
      clear_pulses();
      check("to_press_busy", 32'(busy), 32'h1);
    end
    for (int t = 1; t < TIMEOUT_SECS; t++) begin
      gap = int'($urandom_range(0, 1));
      repeat (gap) tick();
      one_sec = 1'b1;
      tick();
      clear_pulses();
      check("to_count_strike", 32'(strike), 32'h0);
      check("to_count_busy", 32'(busy), 32'h1);
    end
    if (coincide) begin
      one_sec     = 1'b1;
      button_next = 1'b1;
      seq_digit   = nib(tgt, npress);
      tick();
      clear_pulses();
      check("coincide_strike", 32'(strike), 32'h0);
      check("coincide_busy", 32'(busy), 32'h1);
      tick();
    end
    one_sec = 1'b1;
    tick();
    clear_pulses();
    check("timeout_strike", 32'(strike), 32'h1);
    check("timeout_busy", 32'(busy), 32'h0);
    check("timeout_solved", 32'(solved), 32'h0);
    tick();
    check("timeout_after", 32'(strike), 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t;
    int          mode;
    clear_pulses();
    seq_digit = 4'hF;
    reset     = 1'b1;
    tick();
    tick();
    check("rst_seq", 32'(sequence_in), 32'hFFFF);
    check("rst_display", 32'(display), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_solved", 32'(solved), 32'h0);
    check("rst_strike", 32'(strike), 32'h0);
    reset = 1'b0;
    repeat (WAIT_AFTER_RST) tick();
    first_tgt = expand(m_lfsr);
    play_entry(-1);
    play_entry(1);
    play_timeout(1'b0);
    play_timeout(1'b1);
    for (int i = 0; i < 16; i++) begin
      mode = int'($urandom_range(0, 5));
      repeat ($urandom_range(0, 4)) tick();
      case (mode)
        0, 1:    play_entry(-1);
        2, 3:    play_entry(int'($urandom_range(0, 3)));
        4:       play_timeout(1'b0);
        default: play_timeout(1'b1);
      endcase
    end
    start_show(t);
    button_next = 1'b1;
    seq_digit   = nib(t, 0);
    tick();
    clear_pulses();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_seq", 32'(sequence_in), 32'hFFFF);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_display", 32'(display), 32'h0);
    tick();
    reset = 1'b0;
    repeat (WAIT_AFTER_RST) tick();
    start = 1'b1;
    tick();
    clear_pulses();
    check("reseed_target", 32'(sequence_in), 32'(first_tgt));
    check("reseed_busy", 32'(busy), 32'h1);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
